// File: rtl/gl4_upscaler_2x2.sv
// 2x2 nearest-neighbour upscaler: each pixel emitted twice, each line emitted live then replayed
// from a line buffer. Zero latency in LIVE; one bubble cycle per line before replay.
module gl4_upscaler_2x2 #(
  parameter int D_WIDTH   = 8,
  parameter int MAX_WIDTH = 2048,
  parameter int ADDR_W    = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_valid,
  input  logic               up_tlast,
  input  logic               up_tuser,
  output logic               up_ready,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_valid,
  output logic               down_tlast,
  output logic               down_tuser,
  input  logic               down_ready,
  output logic               err_overflow
);

  typedef enum logic [1:0] {LIVE, PREFETCH, REPLAY} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WIDTH - 1);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
  localparam logic [ADDR_W:0]   ONE_L     = (ADDR_W+1)'(1);

  state_t              state, state_nxt;
  logic                ph, ph_nxt;
  logic [ADDR_W-1:0]   wr_addr, wr_addr_nxt;
  logic [ADDR_W-1:0]   rd_addr, rd_addr_nxt;
  logic [ADDR_W:0]     line_len, line_len_nxt;
  logic                err_nxt;

  logic [D_WIDTH-1:0]  mem [MAX_WIDTH];
  logic [D_WIDTH-1:0]  rd_data;
  logic                mem_we;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_ptr;

  logic at_end;
  logic rep_last;

  assign at_end   = (wr_addr == LAST_ADDR);
  assign rep_last = ({1'b0, rd_addr} == (line_len - ONE_L));

  always_comb begin
    state_nxt    = state;
    ph_nxt       = ph;
    wr_addr_nxt  = wr_addr;
    rd_addr_nxt  = rd_addr;
    line_len_nxt = line_len;
    err_nxt      = err_overflow;
    up_ready     = 1'b0;
    down_valid   = 1'b0;
    down_data    = up_data;
    down_tlast   = 1'b0;
    down_tuser   = 1'b0;
    mem_we       = 1'b0;
    rd_en        = 1'b0;
    rd_ptr       = rd_addr;
    if (!rst) begin
      case (state)
        LIVE: begin
          down_valid = up_valid;
          up_ready   = down_ready & ph;
          // a full buffer truncates the line, so its last beat must carry tlast
          down_tlast = ph & (up_tlast | at_end);
          down_tuser = up_tuser & ~ph;
          if (up_valid && down_ready) begin
            if (!ph) begin
              mem_we = 1'b1;
              ph_nxt = 1'b1;
            end else begin
              ph_nxt = 1'b0;
              if (up_tlast || at_end) begin
                line_len_nxt = {1'b0, wr_addr} + ONE_L;
                wr_addr_nxt  = '0;
                state_nxt    = PREFETCH;
                if (!up_tlast) err_nxt = 1'b1;
              end else begin
                wr_addr_nxt = wr_addr + ONE_A;
              end
            end
          end
        end
        PREFETCH: begin
          rd_en       = 1'b1;
          rd_ptr      = '0;
          rd_addr_nxt = '0;
          state_nxt   = REPLAY;
        end
        REPLAY: begin
          down_valid = 1'b1;
          down_data  = rd_data;
          down_tlast = ph & rep_last;
          if (down_ready) begin
            if (!ph) begin
              ph_nxt = 1'b1;
            end else begin
              ph_nxt = 1'b0;
              if (rep_last) begin
                state_nxt = LIVE;
              end else begin
                rd_addr_nxt = rd_addr + ONE_A;
                rd_en       = 1'b1;
                rd_ptr      = rd_addr + ONE_A;
              end
            end
          end
        end
        default: state_nxt = LIVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LIVE;
      ph           <= 1'b0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      line_len     <= '0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_nxt;
      ph           <= ph_nxt;
      wr_addr      <= wr_addr_nxt;
      rd_addr      <= rd_addr_nxt;
      line_len     <= line_len_nxt;
      err_overflow <= err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= up_data;
    if (rd_en)  rd_data      <= mem[rd_ptr];
  end

endmodule

// File: tb/tb_gl4_upscaler_2x2.sv
// Bench for gl4_upscaler_2x2: a large-buffer and a 4-pixel-buffer instance share stimulus;
// output beats are checked against a line-level model of the 2x2 expansion.
module tb_gl4_upscaler_2x2;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       user;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] up_data = '0;
  logic       up_valid = 1'b0;
  logic       up_tlast = 1'b0;
  logic       up_tuser = 1'b0;
  logic       down_ready = 1'b0;
  logic       sel = 1'b0;

  logic [7:0] d_a, d_b;
  logic       ur_a, ur_b, v_a, v_b, l_a, l_b, u_a, u_b, e_a, e_b;

  logic [7:0] o_data;
  logic       o_up_ready, o_valid, o_tlast, o_tuser, o_err;

  int checks = 0;
  int errors = 0;

  beat_t in_q[$];
  beat_t exp_q[$];
  bit    exp_err = 1'b0;
  int    span, bubbles;

  always #5 clk = ~clk;

  gl4_upscaler_2x2 #(.D_WIDTH(8), .MAX_WIDTH(2048), .ADDR_W(11)) dut_big (
    .clk(clk), .rst(rst),
    .up_data(up_data), .up_valid(up_valid), .up_tlast(up_tlast), .up_tuser(up_tuser),
    .up_ready(ur_a),
    .down_data(d_a), .down_valid(v_a), .down_tlast(l_a), .down_tuser(u_a),
    .down_ready(down_ready), .err_overflow(e_a)
  );

  gl4_upscaler_2x2 #(.D_WIDTH(8), .MAX_WIDTH(4), .ADDR_W(2)) dut_small (
    .clk(clk), .rst(rst),
    .up_data(up_data), .up_valid(up_valid), .up_tlast(up_tlast), .up_tuser(up_tuser),
    .up_ready(ur_b),
    .down_data(d_b), .down_valid(v_b), .down_tlast(l_b), .down_tuser(u_b),
    .down_ready(down_ready), .err_overflow(e_b)
  );

  assign o_data     = sel ? d_b  : d_a;
  assign o_up_ready = sel ? ur_b : ur_a;
  assign o_valid    = sel ? v_b  : v_a;
  assign o_tlast    = sel ? l_b  : l_a;
  assign o_tuser    = sel ? u_b  : u_a;
  assign o_err      = sel ? e_b  : e_a;

  // Model: split input into lines (tlast or buffer full); each line -> live doubled, then replay doubled.
  function automatic void build_expected(input int maxw);
    beat_t line[$];
    beat_t b;
    exp_q.delete();
    foreach (in_q[i]) begin
      line.push_back(in_q[i]);
      if (in_q[i].last || line.size() == maxw) begin
        if (!in_q[i].last) exp_err = 1'b1;
        for (int j = 0; j < line.size(); j++) begin
          b = '{d: line[j].d, last: 1'b0, user: line[j].user};
          exp_q.push_back(b);
          b = '{d: line[j].d, last: (j == line.size() - 1), user: 1'b0};
          exp_q.push_back(b);
        end
        for (int j = 0; j < line.size(); j++) begin
          b = '{d: line[j].d, last: 1'b0, user: 1'b0};
          exp_q.push_back(b);
          b = '{d: line[j].d, last: (j == line.size() - 1), user: 1'b0};
          exp_q.push_back(b);
        end
        line.delete();
      end
    end
  endfunction

  function automatic void add_line(input int n, input int base, input bit first_user);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b = '{d: 8'(base + i), last: (i == n - 1), user: (first_user && i == 0)};
      in_q.push_back(b);
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    up_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_err = 1'b0;
    in_q.delete();
    exp_q.delete();
  endtask

  // Drives in_q with optional valid gaps and random backpressure, checking every output transfer.
  task automatic run(input int maxw, input int rdy_pct, input int gap, input int stop_after);
    int    idx = 0, gapc = 0, beats = 0, cyc = 0, first = -1, lastc = -1, idle = 0;
    bit    accepted, pv = 1'b0, pr = 1'b1;
    beat_t prev, obs, e;
    build_expected(maxw);
    while (exp_q.size() > 0 && !(stop_after > 0 && beats >= stop_after)) begin
      if (cyc >= 4000) begin
        checks++; errors++;
        $display("FAIL timeout: %0d beats still expected after %0d cycles", exp_q.size(), cyc);
        break;
      end
      if (idx < in_q.size() && gapc == 0) begin
        up_valid = 1'b1;
        up_data  = in_q[idx].d;
        up_tlast = in_q[idx].last;
        up_tuser = in_q[idx].user;
      end else begin
        up_valid = 1'b0;
        up_data  = 8'($urandom);
        up_tlast = 1'($urandom);
        up_tuser = 1'($urandom);
      end
      down_ready = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      obs = '{d: o_data, last: o_tlast, user: o_tuser};
      if (pv && !pr) begin
        checks++;
        if (!o_valid || obs !== prev) begin
          errors++;
          $display("FAIL hold: valid=%b beat=%h, required valid=1 beat=%h", o_valid, obs, prev);
        end
      end
      if (o_up_ready) begin
        checks++;
        if (!(down_ready && o_valid === up_valid && (!up_valid || o_data === up_data))) begin
          errors++;
          $display("FAIL up_ready: high with down_ready=%b valid=%b/%b data=%h/%h",
                   down_ready, o_valid, up_valid, o_data, up_data);
        end
      end
      if (o_valid && down_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL beat%0d: data=%h tlast=%b tuser=%b, required data=%h tlast=%b tuser=%b",
                   beats, obs.d, obs.last, obs.user, e.d, e.last, e.user);
        end
        beats++;
        if (first < 0) first = cyc;
        lastc = cyc;
      end else if (!o_valid && first >= 0) begin
        idle++;
      end
      pv = o_valid; pr = down_ready; prev = obs;
      accepted = up_valid && o_up_ready;
      @(posedge clk);
      #1;
      if (accepted) begin
        idx++;
        gapc = gap;
      end else if (gapc > 0) begin
        gapc--;
      end
      cyc++;
    end
    up_valid   = 1'b0;
    span       = lastc - first + 1;
    bubbles    = idle;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst = 1'b1;
    up_valid = 1'b1;
    up_data = 8'h55;
    down_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_up_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b up_ready=%b, required 0/0", o_valid, o_up_ready);
    end
    do_reset();
    checks++;
    if (e_a !== 1'b0 || e_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: err=%b%b, required 00", e_a, e_b);
    end
  endtask

  task automatic test_basic(input int rdy_pct);
    sel = 1'b0;
    do_reset();
    add_line(4, 'h10, 1'b1);
    add_line(4, 'h20, 1'b0);
    run(2048, rdy_pct, 0, 0);
    if (rdy_pct == 100) begin
      checks++;
      if (span != 34 || bubbles != 2) begin
        errors++;
        $display("FAIL throughput: span=%0d bubbles=%0d, required 34 and 2", span, bubbles);
      end
    end
  endtask

  task automatic test_single();
    sel = 1'b0;
    do_reset();
    add_line(1, 'hAA, 1'b1);
    add_line(1, 'hBB, 1'b0);
    run(2048, 100, 0, 0);
    checks++;
    if (span != 10 || bubbles != 2) begin
      errors++;
      $display("FAIL single_pixel: span=%0d bubbles=%0d, required 10 and 2", span, bubbles);
    end
  endtask

  task automatic test_overflow();
    sel = 1'b1;
    do_reset();
    add_line(6, 1, 1'b0);
    run(4, 100, 0, 0);
    checks++;
    if (o_err !== exp_err || exp_err !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flag: err=%b, required 1", o_err);
    end
  endtask

  task automatic test_reset_midreplay();
    sel = 1'b0;
    do_reset();
    add_line(4, 'h40, 1'b0);
    run(2048, 100, 0, 10);
    rst = 1'b1;
    down_ready = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_up_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreplay_rst: valid=%b up_ready=%b, required 0/0", o_valid, o_up_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_q.delete();
    exp_q.delete();
    add_line(2, 'h30, 1'b0);
    run(2048, 100, 0, 0);
    checks++;
    if (o_err !== 1'b0 || span != 9) begin
      errors++;
      $display("FAIL after_rst: err=%b span=%0d, required 0 and 9", o_err, span);
    end
  endtask

  task automatic test_gaps();
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      beat_t b;
      b = '{d: 8'($urandom), last: (i == 4), user: (i == 0)};
      in_q.push_back(b);
    end
    run(2048, 100, 3, 0);
    checks++;
    if (bubbles != 13) begin
      errors++;
      $display("FAIL gaps_idle: idle=%0d, required 13", bubbles);
    end
  endtask

  task automatic test_random();
    sel = 1'b1;
    do_reset();
    for (int l = 0; l < 8; l++) begin
      int n;
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        beat_t b;
        b = '{d: 8'($urandom), last: (i == n - 1), user: ($urandom_range(9) == 0)};
        in_q.push_back(b);
      end
    end
    run(4, 60, $urandom_range(0, 2), 0);
    checks++;
    if (o_err !== exp_err) begin
      errors++;
      $display("FAIL random_err: err=%b, required %b", o_err, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic(100);
    test_basic(50);
    test_single();
    test_overflow();
    test_reset_midreplay();
    test_gaps();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
